// File: rtl/cachable_map_if.sv
// Lookup, table-configuration and cache-flush handshake bundle for cachable_map.
// The lock signals exist only when CACHABLE_MAP_LOCK_EN is defined.
interface cachable_map_if #(
  parameter int ADDRESS_WIDTH = 28,
  parameter int NREGIONS      = 4
);
  localparam int IW = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;

  logic                     i_stb;
  logic [ADDRESS_WIDTH-1:0] i_addr;
  logic                     o_valid;
  logic                     o_cachable;
  logic [IW-1:0]            o_region;

  logic                     i_cfg_we;
  logic [IW-1:0]            i_cfg_idx;
  logic [ADDRESS_WIDTH-1:0] i_cfg_base;
  logic [ADDRESS_WIDTH-1:0] i_cfg_mask;
  logic                     i_cfg_en;

  logic                     o_flush_req;
  logic                     i_flush_ack;

`ifdef CACHABLE_MAP_LOCK_EN
  logic                     i_cfg_lock;
  logic                     o_locked;
`endif

  modport master (
    output i_stb, i_addr, i_cfg_we, i_cfg_idx, i_cfg_base, i_cfg_mask, i_cfg_en, i_flush_ack,
    input  o_valid, o_cachable, o_region, o_flush_req
`ifdef CACHABLE_MAP_LOCK_EN
    , output i_cfg_lock, input o_locked
`endif
  );

  modport slave (
    input  i_stb, i_addr, i_cfg_we, i_cfg_idx, i_cfg_base, i_cfg_mask, i_cfg_en, i_flush_ack,
    output o_valid, o_cachable, o_region, o_flush_req
`ifdef CACHABLE_MAP_LOCK_EN
    , input i_cfg_lock, output o_locked
`endif
  );
endinterface

// File: rtl/cachable_map.sv
// Runtime-programmable cachability region decoder with a cache-flush handshake on table rewrites.
// Optional sticky table lock is built when CACHABLE_MAP_LOCK_EN is defined.
module cachable_map #(
  parameter int ADDRESS_WIDTH = 28,
  parameter int NREGIONS      = 4,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_ADDR = {4'b0100, {(ADDRESS_WIDTH-4){1'b0}}},
  parameter logic [ADDRESS_WIDTH-1:0] MEM_MASK = {4'b1111, {(ADDRESS_WIDTH-4){1'b0}}}
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  cachable_map_if.slave bus
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int IW = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;
  localparam logic [IW:0] NREG_LIMIT = (IW+1)'(NREGIONS);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [AW-1:0]         base_q [NREGIONS];
  logic [AW-1:0]         mask_q [NREGIONS];
  logic [NREGIONS-1:0]   valid_q;
  logic                  locked_q;
  logic                  cfg_ok;
  logic                  hit;
  logic [IW-1:0]         hit_idx;
  logic                  valid_r;
  logic                  cachable_r;
  logic [IW-1:0]         region_r;

`ifdef CACHABLE_MAP_LOCK_EN
  // Lock is sampled from the registered bit, so a write in the locking cycle still lands.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      locked_q <= 1'b0;
    else if (bus.i_cfg_lock)
      locked_q <= 1'b1;
  end
  assign bus.o_locked = locked_q;
`else
  assign locked_q = 1'b0;
`endif

  assign cfg_ok = bus.i_cfg_we && ({1'b0, bus.i_cfg_idx} < NREG_LIMIT) && !locked_q;

  // Scan from the top down so the lowest hitting index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NREGIONS-1; k >= 0; k--) begin
      if (valid_q[k] && ((bus.i_addr & mask_q[k]) == base_q[k])) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NREGIONS; k++) begin
        base_q[k]  <= (k == 0) ? MEM_ADDR : '0;
        mask_q[k]  <= (k == 0) ? MEM_MASK : '0;
        valid_q[k] <= (k == 0) && (MEM_ADDR != '0);
      end
    end else if (cfg_ok) begin
      for (int k = 0; k < NREGIONS; k++) begin
        if (bus.i_cfg_idx == IW'(k)) begin
          base_q[k]  <= bus.i_cfg_base;
          mask_q[k]  <= bus.i_cfg_mask;
          valid_q[k] <= bus.i_cfg_en;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // A fresh write always re-arms the flush, even when it coincides with an ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_ok) state_d = FLUSH;
      FLUSH:   if (!cfg_ok && bus.i_flush_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_flush_req = (state_q == FLUSH);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      valid_r    <= 1'b0;
      cachable_r <= 1'b0;
      region_r   <= '0;
    end else begin
      valid_r <= bus.i_stb;
      if (bus.i_stb) begin
        cachable_r <= hit && (state_q == IDLE) && !bus.i_cfg_we;
        region_r   <= hit_idx;
      end
    end
  end

  assign bus.o_valid    = valid_r;
  assign bus.o_cachable = cachable_r;
  assign bus.o_region   = region_r;
endmodule
